// File: rtl/bcd_serial_converter.sv
// Serial binary-to-BCD converter (shift-and-add-3), one operand bit per clock.
// Valid/ready handshakes on both sides; the result register holds the last completed value.
module bcd_serial_converter #(
   parameter int IN_W   = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_W-1:0]       in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic                  out_ovf,
   output logic                  busy
);

   localparam int CNT_W = $clog2(IN_W + 1);
   localparam int BCD_W = 4 * DIGITS;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state;
   logic [IN_W-1:0]    sr;
   logic [CNT_W-1:0]   cnt;
   logic [BCD_W-1:0]   acc;
   logic               ovf;
   logic [BCD_W-1:0]   res_bcd;
   logic               res_ovf;

   logic [BCD_W-1:0]   acc_adj;
   logic [BCD_W-1:0]   acc_nxt;
   logic               ovf_nxt;

   // Per-digit +3 when the digit is 5 or more; digits never carry into each other.
   function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] a);
      logic [BCD_W-1:0] r;
      r = a;
      for (int d = 0; d < DIGITS; d++) begin
         if (a[4*d +: 4] >= 4'd5)
            r[4*d +: 4] = a[4*d +: 4] + 4'd3;
      end
      return r;
   endfunction

   // One double-dabble step: adjust, then shift {acc,sr} left; the bit leaving the top digit is overflow.
   always_comb begin
      acc_adj = add3_digits(acc);
      acc_nxt = {acc_adj[BCD_W-2:0], sr[IN_W-1]};
      ovf_nxt = ovf | acc_adj[BCD_W-1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         acc       <= '0;
         ovf       <= 1'b0;
         cnt       <= '0;
         res_bcd   <= '0;
         res_ovf   <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sr       <= in_data;
                  acc      <= '0;
                  ovf      <= 1'b0;
                  cnt      <= CNT_W'(IN_W);
                  state    <= SHIFT;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            SHIFT: begin
               acc <= acc_nxt;
               ovf <= ovf_nxt;
               sr  <= {sr[IN_W-2:0], 1'b0};
               cnt <= cnt - CNT_W'(1);
               // Final step: publish straight into the result register so it never shows partial values.
               if (cnt == CNT_W'(1)) begin
                  state     <= DONE;
                  res_bcd   <= acc_nxt;
                  res_ovf   <= ovf_nxt;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   assign out_bcd = res_bcd;
   assign out_ovf = res_ovf;

endmodule

// File: tb/tb_bcd_serial_converter.sv
// Scoreboard bench for bcd_serial_converter: an 8-bit/3-digit instance and a
// 5-bit/1-digit instance for truncation and overflow.
module tb_bcd_serial_converter;

   typedef struct {
      logic [11:0] bcd;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rst_b;
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf, a_busy;
   logic [7:0]  a_in_data;
   logic [11:0] a_out_bcd;
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf, b_busy;
   logic [4:0]  b_in_data;
   logic [3:0]  b_out_bcd;

   bcd_serial_converter #(.IN_W(8), .DIGITS(3)) u_dut_a (
      .clk(clk), .reset(rst_a), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_bcd(a_out_bcd), .out_ovf(a_out_ovf), .busy(a_busy));

   bcd_serial_converter #(.IN_W(5), .DIGITS(1)) u_dut_b (
      .clk(clk), .reset(rst_b), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_bcd(b_out_bcd), .out_ovf(b_out_ovf), .busy(b_busy));

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   last_hs = -1;
   bit   period_chk = 1'b0;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input int v, input int d);
      exp_t e;
      int   p;
      p     = 1;
      e.bcd = '0;
      for (int i = 0; i < d; i++) begin
         e.bcd[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      e.ovf = (v >= p);
      return e;
   endfunction

   // Monitors: pop and compare on every output handshake.
   always @(negedge clk) begin
      if (!rst_a && a_out_valid && a_out_ready) begin
         if (qa.size() == 0) begin
            check("a_unexpected_output", 32'(a_out_bcd), 32'hFFFF);
         end else begin
            ea = qa.pop_front();
            check("a_bcd", 32'(a_out_bcd), 32'(ea.bcd));
            check("a_ovf", 32'(a_out_ovf), 32'(ea.ovf));
            for (int d = 0; d < 3; d++)
               check("a_digit_le9", 32'(a_out_bcd[4*d +: 4] <= 4'd9), 32'd1);
            if (period_chk) begin
               if (last_hs >= 0) check("a_period", 32'(cyc - last_hs), 32'd10);
               last_hs = cyc;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_b && b_out_valid && b_out_ready) begin
         if (qb.size() == 0) begin
            check("b_unexpected_output", 32'(b_out_bcd), 32'hFFFF);
         end else begin
            eb = qb.pop_front();
            check("b_bcd", 32'(b_out_bcd), 32'(eb.bcd));
            check("b_ovf", 32'(b_out_ovf), 32'(eb.ovf));
            check("b_digit_le9", 32'(b_out_bcd <= 4'd9), 32'd1);
         end
      end
   end

   // Offer an operand, wait (bounded) for acceptance, record the expected result.
   task automatic send(input bit sel, input int v, input bit keep_valid);
      int n;
      n = 0;
      if (sel) begin b_in_valid = 1'b1; b_in_data = 5'(v); end
      else     begin a_in_valid = 1'b1; a_in_data = 8'(v); end
      while (!(sel ? b_in_ready : a_in_ready) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) check("send_timeout", 32'd1, 32'd0);
      else if (sel) qb.push_back(model(v, 1));
      else          qa.push_back(model(v, 3));
      @(posedge clk); #1;
      if (sel) begin
         if (!keep_valid) b_in_valid = 1'b0;
         b_in_data = ~b_in_data;
      end else begin
         if (!keep_valid) a_in_valid = 1'b0;
         a_in_data = ~a_in_data;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 500) begin
         @(posedge clk);
         n++;
      end
      if (n >= 500) check("drain_timeout", 32'(qa.size() + qb.size()), 32'd0);
      #1;
   endtask

   // Called just after acceptance edge E0: SHIFT for 8 cycles, result visible after E0+8.
   task automatic latency_a(input logic [11:0] prev_bcd);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("a_shift_in_ready", 32'(a_in_ready), 32'd0);
         check("a_shift_out_valid", 32'(a_out_valid), 32'd0);
         check("a_shift_bcd_stable", 32'(a_out_bcd), 32'(prev_bcd));
      end
      @(negedge clk);
      check("a_done_out_valid", 32'(a_out_valid), 32'd1);
   endtask

   initial begin
      int n;
      rst_a = 1'b1; rst_b = 1'b1;
      a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_a = 1'b0; rst_b = 1'b0;
      check("rst_a_in_ready", 32'(a_in_ready), 32'd1);
      check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
      check("rst_a_out_bcd", 32'(a_out_bcd), 32'd0);
      check("rst_a_out_ovf", 32'(a_out_ovf), 32'd0);
      check("rst_a_busy", 32'(a_busy), 32'd0);
      check("rst_b_in_ready", 32'(b_in_ready), 32'd1);
      check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
      check("rst_b_busy", 32'(b_busy), 32'd0);

      send(1'b0, 0, 1'b0);
      latency_a(12'h000);
      drain();

      send(1'b0, 255, 1'b0);
      latency_a(12'h000);
      drain();

      // Backpressure: result held while out_ready is low.
      a_out_ready = 1'b0;
      send(1'b0, 99, 1'b0);
      n = 0;
      while (!a_out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("bp_out_valid_seen", 32'(a_out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_valid", 32'(a_out_valid), 32'd1);
         check("bp_hold_bcd", 32'(a_out_bcd), 32'h099);
      end
      @(posedge clk); #1;
      a_out_ready = 1'b1;
      a_in_valid = 1'b1;
      a_in_data = 8'd7;
      @(posedge clk); #1;
      check("bp_idle_in_ready", 32'(a_in_ready), 32'd1);
      check("bp_idle_busy", 32'(a_busy), 32'd0);
      check("bp_idle_out_valid", 32'(a_out_valid), 32'd0);
      qa.push_back(model(7, 3));
      @(posedge clk); #1;
      check("bp_accept_in_ready", 32'(a_in_ready), 32'd0);
      check("bp_accept_busy", 32'(a_busy), 32'd1);
      a_in_valid = 1'b0;
      drain();

      // Reset mid-conversion discards the operand.
      send(1'b0, 173, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_a = 1'b1;
      void'(qa.pop_back());
      @(posedge clk); #1;
      rst_a = 1'b0;
      check("midrst_in_ready", 32'(a_in_ready), 32'd1);
      check("midrst_out_valid", 32'(a_out_valid), 32'd0);
      check("midrst_out_bcd", 32'(a_out_bcd), 32'd0);
      check("midrst_busy", 32'(a_busy), 32'd0);
      send(1'b0, 42, 1'b0);
      drain();

      // Truncation/overflow on the single-digit instance.
      send(1'b1, 31, 1'b0);
      send(1'b1, 9, 1'b0);
      send(1'b1, 10, 1'b0);
      send(1'b1, 19, 1'b0);
      send(1'b1, 0, 1'b0);
      drain();

      // Back-to-back stream with in_valid and out_ready held high.
      last_hs = -1;
      period_chk = 1'b1;
      for (int v = 0; v < 256; v++) send(1'b0, v, 1'b1);
      a_in_valid = 1'b0;
      drain();
      period_chk = 1'b0;
      check("stream_queue_empty", 32'(qa.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
